// File: rtl/fb_ctrl_pipe_pkg.sv
// Shared definitions for the pipeline control carrier: the control bundle layout,
// the bubble value, forwarding select codes and the hazard decision modes.
package fb_ctrl_pipe_pkg;

    localparam int CTRL_W = 9;

    // Bundle layout: {alu_op[1:0], alu_src, alu_res_src, mem_read, mem_write, branch, mem_to_reg, reg_write}
    localparam int B_ALU_OP_HI   = 8;
    localparam int B_ALU_OP_LO   = 7;
    localparam int B_ALU_SRC     = 6;
    localparam int B_ALU_RES_SRC = 5;
    localparam int B_MEM_READ    = 4;
    localparam int B_MEM_WRITE   = 3;
    localparam int B_BRANCH      = 2;
    localparam int B_MEM_TO_REG  = 1;
    localparam int B_REG_WRITE   = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_NORMAL   = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_REDIRECT = 2'd2
    } hz_mode_e;

    // Taken branches redirect; jal/jalr are marked by alu_res_src and always redirect.
    function automatic logic redirect_of(input ctrl_t c, input logic taken);
        return (c[B_BRANCH] & taken) | c[B_ALU_RES_SRC];
    endfunction

endpackage

// File: rtl/fb_ctrl_pipe_if.sv
// Bundle of ID-side inputs and pipeline control outputs between the core datapath
// (master) and the control carrier / hazard unit (slave).
interface fb_ctrl_pipe_if #(
    parameter int RAW   = 5,
    parameter int CNT_W = 32
);
    import fb_ctrl_pipe_pkg::*;

    logic             id_valid;
    ctrl_t            id_ctrl;
    logic [RAW-1:0]   id_rs1;
    logic [RAW-1:0]   id_rs2;
    logic [RAW-1:0]   id_rd;
    logic             ex_cmp_taken;

    ctrl_t            ex_ctrl;
    ctrl_t            mem_ctrl;
    ctrl_t            wb_ctrl;
    logic [RAW-1:0]   ex_rs1;
    logic [RAW-1:0]   ex_rs2;
    logic [RAW-1:0]   ex_rd;
    logic [RAW-1:0]   mem_rd;
    logic [RAW-1:0]   wb_rd;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             ex_redirect;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_cmp_taken,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
        input  pc_write, ifid_write, ifid_flush, ex_redirect, fwd_a, fwd_b,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_cmp_taken,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
        output pc_write, ifid_write, ifid_flush, ex_redirect, fwd_a, fwd_b,
        output stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fb_ctrl_pipe_fwd_sel.sv
// Per-operand forwarding comparator: picks EX/MEM over MEM/WB over the register file.
module fb_fwd_sel
    import fb_ctrl_pipe_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic           mem_reg_write,
    input  logic [RAW-1:0] mem_rd,
    input  logic           wb_reg_write,
    input  logic [RAW-1:0] wb_rd,
    input  logic [RAW-1:0] ex_rs,
    output fwd_sel_e       sel
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hard-wired zero, so a write to it is never a forwarding source.
    assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs);
    assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fb_ctrl_pipe.sv
// Control-bundle carrier for ID/EX, EX/MEM and MEM/WB plus load-use / redirect
// hazard detection, EX forwarding selects and stall/flush performance counters.
module fb_ctrl_pipe
    import fb_ctrl_pipe_pkg::*;
#(
    parameter int RAW   = 5,
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          rst,
    fb_ctrl_pipe_if.slave bus
);

    ctrl_t            ex_ctrl_reg,  ex_ctrl_next;
    logic [RAW-1:0]   ex_rs1_reg,   ex_rs1_next;
    logic [RAW-1:0]   ex_rs2_reg,   ex_rs2_next;
    logic [RAW-1:0]   ex_rd_reg,    ex_rd_next;
    ctrl_t            mem_ctrl_reg;
    logic [RAW-1:0]   mem_rd_reg;
    ctrl_t            wb_ctrl_reg;
    logic [RAW-1:0]   wb_rd_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    logic     redirect_raw;
    logic     load_use;
    hz_mode_e mode;

    assign redirect_raw = redirect_of(ex_ctrl_reg, bus.ex_cmp_taken);

    assign load_use = ex_ctrl_reg[B_MEM_READ] && (ex_rd_reg != '0) && bus.id_valid &&
                      ((ex_rd_reg == bus.id_rs1) || (ex_rd_reg == bus.id_rs2));

    // Reset forces the normal-flow decision so the front end sees a clean state
    // even before the stage registers have been cleared.
    always_comb begin
        mode = HZ_NORMAL;
        if (!rst) begin
            if (redirect_raw) begin
                mode = HZ_REDIRECT;
            end else if (load_use) begin
                mode = HZ_LOAD_USE;
            end
        end
    end

    always_comb begin
        ex_ctrl_next = BUBBLE;
        ex_rs1_next  = '0;
        ex_rs2_next  = '0;
        ex_rd_next   = '0;
        if ((mode == HZ_NORMAL) && bus.id_valid) begin
            ex_ctrl_next = bus.id_ctrl;
            ex_rs1_next  = bus.id_rs1;
            ex_rs2_next  = bus.id_rs2;
            ex_rd_next   = bus.id_rd;
        end
    end

    // EX/MEM and MEM/WB always advance; only ID/EX chooses between instruction and bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_reg   <= BUBBLE;
            ex_rs1_reg    <= '0;
            ex_rs2_reg    <= '0;
            ex_rd_reg     <= '0;
            mem_ctrl_reg  <= BUBBLE;
            mem_rd_reg    <= '0;
            wb_ctrl_reg   <= BUBBLE;
            wb_rd_reg     <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            ex_ctrl_reg  <= ex_ctrl_next;
            ex_rs1_reg   <= ex_rs1_next;
            ex_rs2_reg   <= ex_rs2_next;
            ex_rd_reg    <= ex_rd_next;
            mem_ctrl_reg <= ex_ctrl_reg;
            mem_rd_reg   <= ex_rd_reg;
            wb_ctrl_reg  <= mem_ctrl_reg;
            wb_rd_reg    <= mem_rd_reg;
            if (mode == HZ_LOAD_USE) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (mode == HZ_REDIRECT) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    logic [RAW-1:0] ex_rs_arr [2];
    fwd_sel_e       fwd_arr   [2];

    assign ex_rs_arr[0] = ex_rs1_reg;
    assign ex_rs_arr[1] = ex_rs2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fb_fwd_sel #(
                .RAW(RAW)
            ) u_fwd_sel (
                .mem_reg_write(mem_ctrl_reg[B_REG_WRITE]),
                .mem_rd       (mem_rd_reg),
                .wb_reg_write (wb_ctrl_reg[B_REG_WRITE]),
                .wb_rd        (wb_rd_reg),
                .ex_rs        (ex_rs_arr[gi]),
                .sel          (fwd_arr[gi])
            );
        end
    endgenerate

    assign bus.ex_ctrl     = ex_ctrl_reg;
    assign bus.mem_ctrl    = mem_ctrl_reg;
    assign bus.wb_ctrl     = wb_ctrl_reg;
    assign bus.ex_rs1      = ex_rs1_reg;
    assign bus.ex_rs2      = ex_rs2_reg;
    assign bus.ex_rd       = ex_rd_reg;
    assign bus.mem_rd      = mem_rd_reg;
    assign bus.wb_rd       = wb_rd_reg;
    assign bus.pc_write    = (mode != HZ_LOAD_USE);
    assign bus.ifid_write  = (mode != HZ_LOAD_USE);
    assign bus.ifid_flush  = (mode == HZ_REDIRECT);
    assign bus.ex_redirect = (mode == HZ_REDIRECT);
    assign bus.fwd_a       = rst ? FWD_RF : fwd_arr[0];
    assign bus.fwd_b       = rst ? FWD_RF : fwd_arr[1];
    assign bus.stall_cnt   = stall_cnt_reg;
    assign bus.flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_fb_ctrl_pipe.sv
// Scenario bench for fb_ctrl_pipe: a queue scoreboard follows every ID/EX load out
// to the WB stage while each task checks hazard, forwarding and counter outputs.
module tb_fb_ctrl_pipe;

    localparam logic [8:0] C_LOAD = 9'h053;  // alu_src, mem_read, mem_to_reg, reg_write
    localparam logic [8:0] C_ADD  = 9'h101;  // alu_op=10, reg_write
    localparam logic [8:0] C_BRLD = 9'h094;  // branch with mem_read set, forces load-use overlap
    localparam logic [8:0] C_JALR = 9'h061;  // alu_src, alu_res_src, reg_write

    typedef struct packed {
        logic [8:0] c;
        logic [4:0] rd;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_stall;
    int   exp_flush;
    exp_t exp_q [$];

    fb_ctrl_pipe_if #(.RAW(5), .CNT_W(32)) bus ();

    fb_ctrl_pipe #(
        .RAW  (5),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [8:0] c, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd);
        bus.id_valid = v;
        bus.id_ctrl  = c;
        bus.id_rs1   = rs1;
        bus.id_rs2   = rs2;
        bus.id_rd    = rd;
    endtask

    task automatic restart_queue();
        exp_t z;
        z = '0;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
    endtask

    // One clock edge; pushes what ID/EX should load now and retires the entry now in WB.
    task automatic advance(input logic [8:0] c, input logic [4:0] rd);
        exp_t e;
        e.c  = c;
        e.rd = rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() > 2) begin
            e = exp_q.pop_front();
            total++;
            if (bus.wb_ctrl !== e.c || bus.wb_rd !== e.rd) begin
                bad++;
                $display("FAIL wb_stage got ctrl=%h rd=%0d expected ctrl=%h rd=%0d",
                         bus.wb_ctrl, bus.wb_rd, e.c, e.rd);
            end else begin
                $display("wb retire ctrl=%h rd=%0d", bus.wb_ctrl, bus.wb_rd);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_id(1'b1, 9'h1FF, 5'd5, 5'd5, 5'd5);
        bus.ex_cmp_taken = 1'b1;
        #1;
        total++;
        if (bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1 || bus.ifid_flush !== 1'b0 ||
            bus.ex_redirect !== 1'b0 || bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs got pc=%b ifw=%b flush=%b redir=%b fa=%b fb=%b expected 1 1 0 0 00 00",
                     bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.ex_redirect, bus.fwd_a, bus.fwd_b);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.ex_ctrl !== 9'h0 || bus.mem_ctrl !== 9'h0 || bus.wb_ctrl !== 9'h0 ||
            bus.ex_rd !== 5'd0 || bus.mem_rd !== 5'd0 || bus.wb_rd !== 5'd0 || bus.ex_rs1 !== 5'd0) begin
            bad++;
            $display("FAIL reset_stages got ex=%h mem=%h wb=%h exrd=%0d expected all zero",
                     bus.ex_ctrl, bus.mem_ctrl, bus.wb_ctrl, bus.ex_rd);
        end
        total++;
        if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0 || bus.pc_write !== 1'b1) begin
            bad++;
            $display("FAIL reset_counters got stall=%0d flush=%0d pc=%b expected 0 0 1",
                     bus.stall_cnt, bus.flush_cnt, bus.pc_write);
        end
        set_id(1'b0, 9'h0, 5'd0, 5'd0, 5'd0);
        bus.ex_cmp_taken = 1'b0;
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        restart_queue();
        $display("reset sequence complete");
    endtask

    task automatic test_load_use();
        set_id(1'b1, C_LOAD, 5'd1, 5'd0, 5'd5);
        #1;
        total++;
        if (bus.pc_write !== 1'b1) begin
            bad++;
            $display("FAIL lu_pre_pc got %b expected 1", bus.pc_write);
        end
        advance(C_LOAD, 5'd5);
        set_id(1'b1, C_ADD, 5'd5, 5'd2, 5'd6);
        #1;
        total++;
        if (bus.pc_write !== 1'b0 || bus.ifid_write !== 1'b0 || bus.ifid_flush !== 1'b0) begin
            bad++;
            $display("FAIL lu_stall got pc=%b ifw=%b flush=%b expected 0 0 0",
                     bus.pc_write, bus.ifid_write, bus.ifid_flush);
        end
        advance(9'h0, 5'd0);
        exp_stall++;
        total++;
        if (bus.ex_ctrl !== 9'h0 || bus.stall_cnt !== 32'(exp_stall)) begin
            bad++;
            $display("FAIL lu_bubble got ex=%h stall=%0d expected 000 %0d",
                     bus.ex_ctrl, bus.stall_cnt, exp_stall);
        end
        total++;
        if (bus.pc_write !== 1'b1) begin
            bad++;
            $display("FAIL lu_release_pc got %b expected 1", bus.pc_write);
        end
        advance(C_ADD, 5'd6);
        total++;
        if (bus.fwd_a !== 2'b01 || bus.fwd_b !== 2'b00 || bus.ex_ctrl !== C_ADD) begin
            bad++;
            $display("FAIL lu_fwd got fa=%b fb=%b ex=%h expected 01 00 %h",
                     bus.fwd_a, bus.fwd_b, bus.ex_ctrl, C_ADD);
        end
        set_id(1'b0, 9'h0, 5'd0, 5'd0, 5'd0);
        advance(9'h0, 5'd0);
    endtask

    task automatic test_rd_zero();
        set_id(1'b1, C_LOAD, 5'd2, 5'd0, 5'd0);
        advance(C_LOAD, 5'd0);
        set_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd3);
        #1;
        total++;
        if (bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1) begin
            bad++;
            $display("FAIL x0_nostall got pc=%b ifw=%b expected 1 1", bus.pc_write, bus.ifid_write);
        end
        advance(C_ADD, 5'd3);
        total++;
        if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00 || bus.stall_cnt !== 32'(exp_stall)) begin
            bad++;
            $display("FAIL x0_nofwd got fa=%b fb=%b stall=%0d expected 00 00 %0d",
                     bus.fwd_a, bus.fwd_b, bus.stall_cnt, exp_stall);
        end
        set_id(1'b0, 9'h0, 5'd0, 5'd0, 5'd0);
        advance(9'h0, 5'd0);
    endtask

    task automatic test_redirect();
        set_id(1'b1, C_BRLD, 5'd3, 5'd4, 5'd9);
        advance(C_BRLD, 5'd9);
        set_id(1'b1, C_ADD, 5'd9, 5'd0, 5'd10);
        bus.ex_cmp_taken = 1'b0;
        #1;
        total++;
        if (bus.ex_redirect !== 1'b0 || bus.pc_write !== 1'b0) begin
            bad++;
            $display("FAIL br_not_taken got redir=%b pc=%b expected 0 0", bus.ex_redirect, bus.pc_write);
        end
        bus.ex_cmp_taken = 1'b1;
        #1;
        total++;
        if (bus.ex_redirect !== 1'b1 || bus.ifid_flush !== 1'b1 || bus.pc_write !== 1'b1 ||
            bus.ifid_write !== 1'b1) begin
            bad++;
            $display("FAIL br_taken got redir=%b flush=%b pc=%b ifw=%b expected 1 1 1 1",
                     bus.ex_redirect, bus.ifid_flush, bus.pc_write, bus.ifid_write);
        end
        advance(9'h0, 5'd0);
        exp_flush++;
        bus.ex_cmp_taken = 1'b0;
        set_id(1'b0, 9'h0, 5'd0, 5'd0, 5'd0);
        #1;
        total++;
        if (bus.stall_cnt !== 32'(exp_stall) || bus.flush_cnt !== 32'(exp_flush) ||
            bus.ex_ctrl !== 9'h0 || bus.ex_redirect !== 1'b0) begin
            bad++;
            $display("FAIL br_counters got stall=%0d flush=%0d ex=%h redir=%b expected %0d %0d 000 0",
                     bus.stall_cnt, bus.flush_cnt, bus.ex_ctrl, bus.ex_redirect, exp_stall, exp_flush);
        end
        advance(9'h0, 5'd0);
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd7);
        advance(C_ADD, 5'd7);
        advance(C_ADD, 5'd7);
        set_id(1'b1, C_ADD, 5'd7, 5'd7, 5'd8);
        #1;
        total++;
        if (bus.pc_write !== 1'b1) begin
            bad++;
            $display("FAIL b2b_nostall got pc=%b expected 1", bus.pc_write);
        end
        advance(C_ADD, 5'd8);
        total++;
        if (bus.fwd_a !== 2'b10 || bus.fwd_b !== 2'b10 || bus.ex_rs1 !== 5'd7 || bus.ex_rs2 !== 5'd7) begin
            bad++;
            $display("FAIL b2b_fwd got fa=%b fb=%b rs1=%0d rs2=%0d expected 10 10 7 7",
                     bus.fwd_a, bus.fwd_b, bus.ex_rs1, bus.ex_rs2);
        end
        set_id(1'b0, 9'h0, 5'd0, 5'd0, 5'd0);
        advance(9'h0, 5'd0);
        total++;
        if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
            bad++;
            $display("FAIL b2b_idle got fa=%b fb=%b expected 00 00", bus.fwd_a, bus.fwd_b);
        end
        advance(9'h0, 5'd0);
        advance(9'h0, 5'd0);
    endtask

    task automatic test_jalr();
        set_id(1'b1, C_JALR, 5'd4, 5'd0, 5'd1);
        advance(C_JALR, 5'd1);
        set_id(1'b1, C_ADD, 5'd2, 5'd3, 5'd4);
        #1;
        total++;
        if (bus.ex_redirect !== 1'b1 || bus.ifid_flush !== 1'b1 || bus.pc_write !== 1'b1) begin
            bad++;
            $display("FAIL jalr_redirect got redir=%b flush=%b pc=%b expected 1 1 1",
                     bus.ex_redirect, bus.ifid_flush, bus.pc_write);
        end
        advance(9'h0, 5'd0);
        exp_flush++;
        set_id(1'b0, 9'h0, 5'd0, 5'd0, 5'd0);
        #1;
        total++;
        if (bus.ex_ctrl !== 9'h0 || bus.ex_redirect !== 1'b0 || bus.mem_ctrl !== C_JALR) begin
            bad++;
            $display("FAIL jalr_slot1 got ex=%h redir=%b mem=%h expected 000 0 %h",
                     bus.ex_ctrl, bus.ex_redirect, bus.mem_ctrl, C_JALR);
        end
        advance(9'h0, 5'd0);
        total++;
        if (bus.wb_ctrl !== C_JALR || bus.ex_ctrl !== 9'h0 || bus.flush_cnt !== 32'(exp_flush)) begin
            bad++;
            $display("FAIL jalr_wb got wb=%h ex=%h flush=%0d expected %h 000 %0d",
                     bus.wb_ctrl, bus.ex_ctrl, bus.flush_cnt, C_JALR, exp_flush);
        end
        advance(9'h0, 5'd0);
    endtask

    task automatic test_reset_mid();
        set_id(1'b1, C_LOAD, 5'd0, 5'd0, 5'd5);
        advance(C_LOAD, 5'd5);
        set_id(1'b1, C_ADD, 5'd5, 5'd5, 5'd6);
        #1;
        total++;
        if (bus.pc_write !== 1'b0) begin
            bad++;
            $display("FAIL mid_stall_setup got pc=%b expected 0", bus.pc_write);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1 || bus.fwd_a !== 2'b00) begin
            bad++;
            $display("FAIL mid_rst_outputs got pc=%b ifw=%b fa=%b expected 1 1 00",
                     bus.pc_write, bus.ifid_write, bus.fwd_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (bus.ex_ctrl !== 9'h0 || bus.mem_ctrl !== 9'h0 || bus.wb_ctrl !== 9'h0 ||
            bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0 || bus.pc_write !== 1'b1) begin
            bad++;
            $display("FAIL mid_rst_clear got ex=%h mem=%h wb=%h stall=%0d flush=%0d pc=%b expected 000 000 000 0 0 1",
                     bus.ex_ctrl, bus.mem_ctrl, bus.wb_ctrl, bus.stall_cnt, bus.flush_cnt, bus.pc_write);
        end
        exp_stall = 0;
        exp_flush = 0;
        restart_queue();
        advance(C_ADD, 5'd6);
        set_id(1'b0, 9'h0, 5'd0, 5'd0, 5'd0);
        advance(9'h0, 5'd0);
        advance(9'h0, 5'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.ex_cmp_taken = 1'b0;
        set_id(1'b0, 9'h0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_rd_zero();
        test_redirect();
        test_back_to_back();
        test_jalr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_ctrl_pipe.md
# fb_ctrl_pipe

Pipeline control carrier and hazard unit for the five-stage core. It consumes the per-instruction control bundle produced by the opcode decoder in ID and carries it through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use and control hazards, generates the stall, flush and bubble signals for the front end, and drives the EX operand forwarding selects. Two performance counters record stall and flush cycles.

## Interface
Parameters:
- RAW = 5: register-address width.
- CNT_W = 32: performance-counter width.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  9  control bundle from the decoder: {alu_op[1:0], alu_src, alu_res_src, mem_read, mem_write, branch, mem_to_reg, reg_write}.
- id_rs1, id_rs2, id_rd  in  RAW  register fields of the ID instruction.
- ex_cmp_taken  in  1  branch comparator result in EX.
- ex_ctrl, mem_ctrl, wb_ctrl  out  9  registered control bundles for EX, MEM and WB.
- ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd  out  RAW  registered register addresses.
- pc_write  out  1  PC may advance.
- ifid_write  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID loads a bubble.
- ex_redirect  out  1  EX redirects the PC.
- fwd_a, fwd_b  out  2  EX operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- Bundle bit positions and the canonical bubble value (all zero) are defined in a single place.
- ex_redirect = (ex_ctrl.branch & ex_cmp_taken) | ex_ctrl.alu_res_src. This covers taken branches, jal and jalr.
- Load-use hazard: load_use = ex_ctrl.mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
- Priority order: redirect, then load-use, then normal.
  - Redirect: pc_write=1, ifid_write=1, ifid_flush=1, ID/EX loads a bubble. Load-use is ignored in this cycle.
  - Load-use: pc_write=0, ifid_write=0, ifid_flush=0, ID/EX loads a bubble.
  - Normal: pc_write=1, ifid_write=1, ifid_flush=0. ID/EX loads id_ctrl, or a bubble if !id_valid.
- EX/MEM and MEM/WB always advance; they never stall.
- A bubble zeroes the bundle and all RAW fields.
- Forwarding for operand a; operand b is identical using ex_rs2:
  - If mem_ctrl.reg_write & mem_rd != 0 & mem_rd == ex_rs1, then 10.
  - Else if wb_ctrl.reg_write & wb_rd != 0 & wb_rd == ex_rs1, then 01.
  - Else 00.
  - The EX/MEM match wins when both stages match.
- rd == 0 never forwards and never causes a stall.
- stall_cnt increments in every load-use stall cycle that is not overridden by a redirect.
- flush_cnt increments in every ex_redirect cycle.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset state: all stage bundles and addresses are 0 (bubbles), both counters are 0.
  - While reset is held, the outputs are pc_write=1, ifid_write=1, ifid_flush=0, ex_redirect=0, fwd_a=fwd_b=00.
- Reset asserted mid-stall or mid-flush clears all state at the next edge. No hazard survives reset.
- Stage registers have a latency of one cycle per stage: id_ctrl sampled at edge n appears on ex_ctrl after n, mem_ctrl after n+1, wb_ctrl after n+2.
- pc_write, ifid_write, ifid_flush, ex_redirect and fwd_* are combinational from current state and ID inputs, valid in the same cycle.
- A load-use stall lasts exactly one cycle. After the bubble enters EX the load sits in MEM, and the dependent instruction proceeds with fwd=01 on the following cycle.
- A redirect flushes exactly two younger instructions (IF/ID and ID/EX). A consecutive redirect is impossible because EX then holds a bubble.

## Structure
- Shared defines: bundle field indices, bundle width (9), BUBBLE constant, forwarding select encodings (FWD_RF, FWD_MEM, FWD_WB).
- One natural sub-module: fb_fwd_sel, the per-operand forwarding comparator, instantiated twice. Everything else is flat.

## Test plan
- Reset with id_ctrl nonzero held for 3 cycles → all stage bundles 0, counters 0, pc_write=1.
- Load x5 (mem_read, rd=5) followed by add with rs1=5 → one cycle with pc_write=0, ifid_write=0, ex_ctrl=0 on the next edge, then fwd_a=01, stall_cnt=1.
- Load with rd=0 followed by a consumer of x0 → no stall, fwd_a=00.
- Branch in EX with ex_cmp_taken=1 while a load-use condition is present in ID → ex_redirect=1, ifid_flush=1, pc_write=1, stall_cnt unchanged, flush_cnt=1.
- Back-to-back writers of x7 (EX/MEM and MEM/WB both rd=7) with EX rs1=rs2=7 → fwd_a=fwd_b=10.
- jalr (alu_res_src=1, reg_write=1) reaching EX → ex_redirect=1. Two younger slots are bubbles, and the jalr bundle appears in wb_ctrl two edges later.
